cmd_queue: RTL and testbench
============================

// Module: cmd_queue
// PURPOSE
//  Upstream stage of the game engine: buffers 16-bit player command words, filters illegal ones
//  and presents legal commands to the engine one at a time via valid/ready.
//  Legality is judged against game mode (exploring vs. on enemy) and the hacks enable.
//  Replaces the engine's free-running eip/input_data walk with a flow-controlled stream.
// PARAMETERS
//  DEPTH  8   FIFO entries (power of two, >=2)
//  CMD_W  16  command word width
//  CNT_W  8   width of accept/reject statistics counters (saturating)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst_n      in   1        synchronous active-low reset
//  in_valid   in   1        producer has a command word
//  in_ready   out  1        queue can take a word this cycle
//  in_cmd     in   CMD_W    raw command word
//  on_enemy   in   1        engine mode: 1 = combat, 0 = exploring
//  hacks_en   in   1        1 = cheat command 0x10 allowed
//  out_valid  out  1        head entry valid
//  out_ready  in   1        engine consumes head this cycle
//  out_cmd    out  CMD_W    raw word at head
//  out_op     out  3        decoded op at head (codes below)
//  rej_pulse  out  1        one-cycle pulse: word accepted by handshake but dropped as illegal
//  acc_count  out  CNT_W    legal words enqueued since reset
//  rej_count  out  CNT_W    illegal words dropped since reset
//  level      out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): FIFO empty, pointers 0, level 0, out_valid 0, rej_pulse 0,
//    both counters 0. in_ready forced 0 while rst_n==0.
//  - Input handshake: word transferred when in_valid & in_ready. in_ready = !full | out_ready
//    (full queue may accept when head is dequeued same cycle).
//  - Legality, evaluated on the transfer cycle with that cycle's on_enemy/hacks_en:
//    exploring: 1..4 legal; combat: 5,6 legal; 0x10 legal in either mode iff hacks_en;
//    every other value (0, 7..0xF, >0x10) illegal.
//  - Legal word: written at wr_ptr, wr_ptr+1 (wraps mod DEPTH), acc_count+1.
//    Illegal word: not written, rej_pulse=1 next cycle, rej_count+1. Illegal words still require
//    in_ready (no bypass of back-pressure).
//  - Counters saturate at 2^CNT_W-1; never wrap.
//  - Output: out_valid = (level!=0); out_cmd/out_op from head, combinational from storage.
//    Dequeue when out_valid & out_ready: rd_ptr+1 wrapping. out_ready with out_valid=0 ignored.
//  - Latency: legal word accepted in cycle N is visible at out_valid no earlier than N+1
//    (no same-cycle pass-through, even when empty).
//  - Simultaneous enqueue+dequeue: level unchanged; valid at full and at empty (empty case:
//    no dequeue occurs, level becomes 1). Illegal word + dequeue: level-1.
//  - out_op: 0 RIGHT(1), 1 LEFT(2), 2 UP(3), 3 DOWN(4), 4 ATTACK(5), 5 RUN(6), 6 NOSHROUD(0x10);
//    7 never produced.
//  - Mode change after enqueue does not re-validate queued entries; engine owns late rejection.
//  - Reset mid-operation discards all queued entries; no partial transfer survives.
// STRUCTURE
//  - Shared package/include game_defs: command code constants (CMD_RIGHT..CMD_NOSHROUD=16'h10),
//    OP_* encodings, map tile IDs already used by the engine.
//  - One sub-module: cmd_legal_chk (combinational: cmd, on_enemy, hacks_en -> legal, op).
//    FIFO storage/pointers/counters stay in cmd_queue.
// TESTING
//  - Reset: hold rst_n=0 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, counts 0, level 0.
//  - Explore stream 1,2,3,4, out_ready=1 -> out_op 0,1,2,3 in order, each 1 cycle after accept, acc=4.
//  - on_enemy=1, send 1,5,6 -> 1 dropped (rej_pulse once, rej=1), out_cmd 5 then 6.
//  - hacks_en=0 send 0x10 -> rejected; hacks_en=1 send 0x10 -> out_op=6; send 0,7,0x11 -> rej+3.
//  - out_ready=0, push 9 legal words -> in_ready=0 after 8, level=8; then out_ready=1 with
//    in_valid=1 -> in_ready=1, level holds 8, FIFO order preserved across pointer wrap.
//  - CNT_W=2 build, 5 illegal words -> rej_count sticks at 3; reset mid-queue (level=5) -> level 0.

Source files
------------

// File: rtl/cmd_queue_pkg.sv
// Shared game definitions: command word codes and decoded op encodings.
package cmd_queue_pkg;

  localparam logic [15:0] CMD_RIGHT    = 16'h0001;
  localparam logic [15:0] CMD_LEFT     = 16'h0002;
  localparam logic [15:0] CMD_UP       = 16'h0003;
  localparam logic [15:0] CMD_DOWN     = 16'h0004;
  localparam logic [15:0] CMD_ATTACK   = 16'h0005;
  localparam logic [15:0] CMD_RUN      = 16'h0006;
  localparam logic [15:0] CMD_NOSHROUD = 16'h0010;

  // OP_NONE is the decoder's idle value and never reaches the queue output.
  typedef enum logic [2:0] {
    OP_RIGHT    = 3'd0,
    OP_LEFT     = 3'd1,
    OP_UP       = 3'd2,
    OP_DOWN     = 3'd3,
    OP_ATTACK   = 3'd4,
    OP_RUN      = 3'd5,
    OP_NOSHROUD = 3'd6,
    OP_NONE     = 3'd7
  } op_e;

endpackage

// File: rtl/cmd_queue_if.sv
// Command stream bundle: producer-side and engine-side valid/ready handshakes.
interface cmd_queue_if import cmd_queue_pkg::*; #(
  parameter int unsigned CMD_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [CMD_W-1:0] in_cmd;
  logic             out_valid;
  logic             out_ready;
  logic [CMD_W-1:0] out_cmd;
  op_e              out_op;

  // master: the environment (producer + engine); slave: the queue.
  modport master (
    output in_valid, in_cmd, out_ready,
    input  in_ready, out_valid, out_cmd, out_op
  );
  modport slave (
    input  in_valid, in_cmd, out_ready,
    output in_ready, out_valid, out_cmd, out_op
  );
endinterface

// File: rtl/cmd_queue_legal_chk.sv
// Combinational legality check and op decode for one command word.
module cmd_legal_chk import cmd_queue_pkg::*; #(
  parameter int unsigned CMD_W = 16
) (
  input  logic [CMD_W-1:0] cmd,
  input  logic             on_enemy,
  input  logic             hacks_en,
  output logic             legal,
  output op_e              op
);

  // Decode the word and qualify it with the current mode.
  always_comb begin
    legal = 1'b0;
    op    = OP_NONE;
    case (cmd)
      CMD_W'(CMD_RIGHT):    begin op = OP_RIGHT;    legal = ~on_enemy; end
      CMD_W'(CMD_LEFT):     begin op = OP_LEFT;     legal = ~on_enemy; end
      CMD_W'(CMD_UP):       begin op = OP_UP;       legal = ~on_enemy; end
      CMD_W'(CMD_DOWN):     begin op = OP_DOWN;     legal = ~on_enemy; end
      CMD_W'(CMD_ATTACK):   begin op = OP_ATTACK;   legal = on_enemy;  end
      CMD_W'(CMD_RUN):      begin op = OP_RUN;      legal = on_enemy;  end
      CMD_W'(CMD_NOSHROUD): begin op = OP_NOSHROUD; legal = hacks_en;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/cmd_queue.sv
// Command queue: FIFO of legal player commands with drop statistics.
module cmd_queue import cmd_queue_pkg::*; #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CMD_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cmd_queue_if.slave                 bus,
  input  logic                       on_enemy,
  input  logic                       hacks_en,
  output logic                       rej_pulse,
  output logic [CNT_W-1:0]           acc_count,
  output logic [CNT_W-1:0]           rej_count,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  typedef struct packed {
    op_e              op;
    logic [CMD_W-1:0] cmd;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             xfer;
  logic             legal;
  logic             wr_en;
  logic             drop;
  logic             deq;
  op_e              chk_op;

  cmd_legal_chk #(.CMD_W(CMD_W)) u_chk (
    .cmd      (bus.in_cmd),
    .on_enemy (on_enemy),
    .hacks_en (hacks_en),
    .legal    (legal),
    .op       (chk_op)
  );

  // A full queue still accepts when the head leaves in the same cycle.
  assign full          = (level == LVL_W'(DEPTH));
  assign bus.in_ready  = rst_n & (~full | bus.out_ready);
  assign bus.out_valid = (level != '0);
  assign bus.out_cmd   = mem[rd_ptr].cmd;
  assign bus.out_op    = mem[rd_ptr].op;

  assign xfer  = bus.in_valid & bus.in_ready;
  assign wr_en = xfer & legal;
  assign drop  = xfer & ~legal;
  assign deq   = bus.out_valid & bus.out_ready;

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{op: chk_op, cmd: bus.in_cmd};
  end

  // Pointers, occupancy, drop pulse and saturating statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rej_pulse <= 1'b0;
      acc_count <= '0;
      rej_count <= '0;
    end else begin
      rej_pulse <= drop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (deq)   rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(wr_en) - LVL_W'(deq);
      if (wr_en && acc_count != '1) acc_count <= acc_count + 1'b1;
      if (drop  && rej_count != '1) rej_count <= rej_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_queue.sv
// Self-checking bench for cmd_queue: vector table, corner sequences, random vs. model.
module tb_cmd_queue;
  import cmd_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CMAX  = 255;

  logic       clk;
  logic       rst_n, rst2_n;
  logic       on_enemy, hacks_en;
  logic       rej_pulse, rej_pulse2;
  logic [7:0] acc_count, rej_count;
  logic [1:0] acc_count2, rej_count2;
  logic [3:0] level, level2;

  cmd_queue_if #(.CMD_W(16)) bus ();
  cmd_queue_if #(.CMD_W(16)) bus2 ();

  cmd_queue #(.DEPTH(8), .CMD_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .on_enemy(on_enemy), .hacks_en(hacks_en),
    .rej_pulse(rej_pulse), .acc_count(acc_count), .rej_count(rej_count), .level(level)
  );

  cmd_queue #(.DEPTH(8), .CMD_W(16), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.slave), .on_enemy(1'b0), .hacks_en(1'b0),
    .rej_pulse(rej_pulse2), .acc_count(acc_count2), .rej_count(rej_count2), .level(level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: plain queues and counters driven by the command rules.
  int mq[$];
  int mop[$];
  int m_acc = 0;
  int m_rej = 0;
  bit m_pulse = 0;

  function automatic int ref_op(int c, bit enemy, bit hacks);
    if (!enemy && c >= 1 && c <= 4) return c - 1;
    if (enemy && (c == 5 || c == 6)) return c - 1;
    if (hacks && c == 16) return 6;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit er;
    er = rst_n && (mq.size() < DEPTH || bus.out_ready);
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_cmd", 32'(bus.out_cmd), mq[0]);
      chk("out_op", 32'(bus.out_op), mop[0]);
    end
    chk("level", 32'(level), mq.size());
    chk("rej_pulse", 32'(rej_pulse), 32'(m_pulse));
    chk("acc_count", 32'(acc_count), m_acc);
    chk("rej_count", 32'(rej_count), m_rej);
  endtask

  // Advance one clock, updating the model from the inputs held over the edge.
  task automatic advance();
    bit er;
    int lo;
    er = rst_n && (mq.size() < DEPTH || bus.out_ready);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); mop.delete();
      m_acc = 0; m_rej = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (mq.size() != 0 && bus.out_ready) begin
        void'(mq.pop_front());
        void'(mop.pop_front());
      end
      if (bus.in_valid && er) begin
        lo = ref_op(int'(bus.in_cmd), on_enemy, hacks_en);
        if (lo >= 0) begin
          mq.push_back(int'(bus.in_cmd));
          mop.push_back(lo);
          if (m_acc < CMAX) m_acc++;
        end else begin
          m_pulse = 1;
          if (m_rej < CMAX) m_rej++;
        end
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit iv; int cmd; bit en; bit hk; bit ordy;
    bit e_ir; bit e_ov; int e_cmd; int e_op; int e_lvl; bit e_rp; int e_acc; int e_rej;
  } vec_t;

  function automatic vec_t v(bit iv, int cmd, bit en, bit hk, bit ordy, bit e_ir, bit e_ov,
                             int e_cmd, int e_op, int e_lvl, bit e_rp, int e_acc, int e_rej);
    vec_t r;
    r.iv = iv; r.cmd = cmd; r.en = en; r.hk = hk; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_cmd = e_cmd; r.e_op = e_op; r.e_lvl = e_lvl;
    r.e_rp = e_rp; r.e_acc = e_acc; r.e_rej = e_rej;
    return r;
  endfunction

  vec_t tv[17];

  initial begin
    int k;
    int words[9];
    int bias;
    // Expected outputs are those seen during the row's cycle, before its clock edge.
    tv[0]  = v(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = v(1, 2, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 0);
    tv[2]  = v(1, 3, 0, 0, 1, 1, 1, 2, 1, 1, 0, 2, 0);
    tv[3]  = v(1, 4, 0, 0, 1, 1, 1, 3, 2, 1, 0, 3, 0);
    tv[4]  = v(0, 0, 0, 0, 1, 1, 1, 4, 3, 1, 0, 4, 0);
    tv[5]  = v(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4, 0);
    tv[6]  = v(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4, 0);
    tv[7]  = v(1, 5, 1, 0, 1, 1, 0, 0, 0, 0, 1, 4, 1);
    tv[8]  = v(1, 6, 1, 0, 1, 1, 1, 5, 4, 1, 0, 5, 1);
    tv[9]  = v(0, 0, 1, 0, 1, 1, 1, 6, 5, 1, 0, 6, 1);
    tv[10] = v(1, 16, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6, 1);
    tv[11] = v(1, 16, 0, 1, 1, 1, 0, 0, 0, 0, 1, 6, 2);
    tv[12] = v(1, 0, 0, 1, 1, 1, 1, 16, 6, 1, 0, 7, 2);
    tv[13] = v(1, 7, 0, 1, 1, 1, 0, 0, 0, 0, 1, 7, 3);
    tv[14] = v(1, 17, 0, 1, 1, 1, 0, 0, 0, 0, 1, 7, 4);
    tv[15] = v(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 7, 5);
    tv[16] = v(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 7, 5);

    rst_n = 0; rst2_n = 0;
    on_enemy = 0; hacks_en = 0;
    bus.in_valid = 1; bus.in_cmd = 16'h0001; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.in_cmd = '0; bus2.out_ready = 0;
    @(negedge clk);

    // Reset held with a word offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      if (i > 0) begin
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_acc", 32'(acc_count), 0);
        chk("rst_rej", 32'(rej_count), 0);
        chk("rst_pulse", 32'(rej_pulse), 0);
      end
      advance();
    end
    rst_n = 1;

    // Vector table: explore stream, combat filtering, hacks gating.
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = tv[i].iv; bus.in_cmd = 16'(tv[i].cmd);
      on_enemy = tv[i].en; hacks_en = tv[i].hk; bus.out_ready = tv[i].ordy;
      #1;
      chk($sformatf("tv%0d_in_ready", i), 32'(bus.in_ready), 32'(tv[i].e_ir));
      chk($sformatf("tv%0d_out_valid", i), 32'(bus.out_valid), 32'(tv[i].e_ov));
      if (tv[i].e_ov) begin
        chk($sformatf("tv%0d_out_cmd", i), 32'(bus.out_cmd), tv[i].e_cmd);
        chk($sformatf("tv%0d_out_op", i), 32'(bus.out_op), tv[i].e_op);
      end
      chk($sformatf("tv%0d_level", i), 32'(level), tv[i].e_lvl);
      chk($sformatf("tv%0d_rej_pulse", i), 32'(rej_pulse), 32'(tv[i].e_rp));
      chk($sformatf("tv%0d_acc", i), 32'(acc_count), tv[i].e_acc);
      chk($sformatf("tv%0d_rej", i), 32'(rej_count), tv[i].e_rej);
      advance();
    end

    // Fill to full with the engine stalled, then stream through a full queue across the wrap.
    for (int i = 0; i < 9; i++) words[i] = (i % 5 == 4) ? 16 : (i % 5) + 1;
    on_enemy = 0; hacks_en = 1; bus.out_ready = 0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = 1; bus.in_cmd = 16'(words[k % 9]);
      #1;
      model_check();
      if (bus.in_ready) k++;
      advance();
    end
    #1;
    chk("full_level", 32'(level), 8);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_accepted", k, 8);
    bus.out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      bus.in_cmd = 16'(words[k % 9]);
      #1;
      chk("full_deq_in_ready", 32'(bus.in_ready), 1);
      chk("full_deq_level", 32'(level), 8);
      model_check();
      k++;
      advance();
    end
    bus.in_valid = 0;
    for (int c = 0; c < 10; c++) begin
      #1; model_check(); advance();
    end

    // Random traffic with mode flips, back-pressure phases and occasional reset.
    bias = 50;
    for (int c = 0; c < 1500; c++) begin
      int pick;
      if (c % 100 == 0) bias = (c / 100 % 3 == 0) ? 15 : ((c / 100 % 3 == 1) ? 85 : 50);
      pick = $urandom_range(0, 11);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_cmd = (pick == 11) ? 16'($urandom) : ((pick == 10) ? 16'h0010 : 16'(pick));
      if ($urandom_range(0, 15) == 0) on_enemy = ~on_enemy;
      if ($urandom_range(0, 15) == 0) hacks_en = ~hacks_en;
      bus.out_ready = ($urandom_range(0, 99) < bias);
      rst_n = ($urandom_range(0, 299) != 0);
      #1;
      model_check();
      advance();
      rst_n = 1;
    end
    bus.in_valid = 0;

    // Narrow-counter build: saturation, then reset with entries queued.
    rst2_n = 1;
    bus2.in_valid = 1; bus2.in_cmd = 16'h0000; bus2.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1; chk("s_ill_in_ready", 32'(bus2.in_ready), 1);
      @(posedge clk); @(negedge clk);
    end
    bus2.in_valid = 0;
    #1;
    chk("s_rej_sat", 32'(rej_count2), 3);
    chk("s_acc_zero", 32'(acc_count2), 0);
    chk("s_level_zero", 32'(level2), 0);
    bus2.in_valid = 1; bus2.in_cmd = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
    end
    bus2.in_valid = 0;
    #1;
    chk("s_level5", 32'(level2), 5);
    chk("s_acc_sat", 32'(acc_count2), 3);
    chk("s_rej_hold", 32'(rej_count2), 3);
    chk("s_out_cmd", 32'(bus2.out_cmd), 1);
    rst2_n = 0;
    #1;
    chk("s_rst_in_ready", 32'(bus2.in_ready), 0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("s_rst_level", 32'(level2), 0);
    chk("s_rst_out_valid", 32'(bus2.out_valid), 0);
    chk("s_rst_acc", 32'(acc_count2), 0);
    chk("s_rst_rej", 32'(rej_count2), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
